dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data-memory/I-O port (RAM plus memory-mapped I/O space) between the CPU data path (port 0) and a debug/loader master (port 1). It sits between the requesters and the data-memory block, and drives that block's write enable, address and write data. It also returns read data with a one-cycle valid strobe. Arbitration is round-robin with a bounded burst length, so neither master can starve the other.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive grants to one port while the other is requesting (legal 1..255)

- clock  in  1  single system clock, rising edge active
- resetn  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, ports 0 (CPU) / 1 (debug)
- we0 / we1  in  1  1 = write, 0 = read; valid while reqN high
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational grant; access takes effect in a cycle where reqN & gntN
- rvalid0 / rvalid1  out  1  registered pulse: read data for port N is on rdata
- rdata  out  DATA_W  shared read data, registered copy of m_dataout
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_datain  out  DATA_W  memory write data
- m_dataout  in  DATA_W  memory read data, valid one cycle after the address is presented
- owner  out  2  debug view of state: 0 IDLE, 1 OWN0, 2 OWN1

## Operation
- States: IDLE, OWN0, OWN1. A registered last-owner bit lp is used only for ties in IDLE. A burst counter cnt is 8 bits wide and saturates at STARVE_LIMIT.
- The grant decision is combinational from state, cnt, lp, req0 and req1. At most one grant is high; no grant is given without the matching req.
  - IDLE, single request: grant that port.
  - IDLE, both requesting: grant the port != lp.
  - OWNn: keep reqn's grant unless the other port requests and cnt == STARVE_LIMIT. In that case, or when reqn is low and the other port requests, grant the other port.
  - No requests: no grant.
- Next state equals the granted port (OWN0/OWN1), or IDLE if no grant.
- cnt update:
  - Granted port == current owner: cnt+1, saturating.
  - Ownership change, or grant from IDLE: cnt = 1.
  - IDLE next: cnt = 0.
- lp is updated to the granted port on every grant.
- Memory mux (combinational):
  - m_addr / m_datain follow the granted port; with no grant they are 0.
  - m_we = resetn & (gnt0&we0 | gnt1&we1).
- Read return: a granted read (we=0) by port n sets rvalidn high in the next cycle, with rdata = m_dataout captured at that edge. rvalid is a one-cycle pulse per read; back-to-back reads give back-to-back pulses.
- A granted write produces no rvalid.
- A requester that does not receive a grant must hold req, we, addr and wdata stable. The arbiter does not check this.

## Timing
- Reset values:
  - state IDLE, cnt 0, lp 1 (port 0 wins the first tie).
  - rvalid0 = rvalid1 = 0, rdata 0.
  - gnt0 = gnt1 = 0 and m_we 0 while resetn low.
- Grant latency: 0 cycles. A request is granted in the same cycle if it wins arbitration.
- Read latency: 1 cycle from the grant cycle to rvalid/rdata.
- Write latency: the write occurs in the grant cycle.
- Contention: with both ports requesting continuously, grants alternate in runs of exactly STARVE_LIMIT cycles. With STARVE_LIMIT = 1 they alternate every cycle.
- Worst-case wait for a requester is STARVE_LIMIT cycles.
- Simultaneous release and request: owner drops req in the same cycle the other port raises it. The other port is granted that cycle with cnt = 1, with no idle bubble.
- Reset mid-operation: asynchronous clear to the reset values. An rvalid due in the next cycle is dropped. An in-flight write is suppressed immediately via m_we gating.
- cnt saturates and never wraps. A lone requester holds ownership indefinitely.

## Test plan
- Reset: resetn=0 with req0=req1=1 and we0=1 -> gnt0=gnt1=0, m_we=0, rvalid=0, owner=0. Release reset -> gnt0=1 in the first cycle (lp=1 tie rule).
- Single read: req0 only, we0=0, addr0=0x10, memory returns 0xDEADBEEF -> gnt0 in cycle 0; rvalid0=1 and rdata=0xDEADBEEF in cycle 1; rvalid1 stays 0.
- Contention, STARVE_LIMIT=4: both ports hold req for 16 cycles -> gnt0 in cycles 0-3, gnt1 in 4-7, gnt0 in 8-11, gnt1 in 12-15; never both high.
- Handoff without bubble: port 1 owns, drops req1 in cycle k while req0 rises in cycle k -> gnt0=1 in cycle k, owner=1 in cycle k+1.
- Write path: port 1 writes 0x12345678 to 0x80 -> m_we=1, m_addr=0x80, m_datain=0x12345678 in the grant cycle; no rvalid1.
- Reset mid-read: assert resetn=0 in the cycle after a granted read -> rvalid0 stays 0, state returns to IDLE, cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port used by dmem_arbiter.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_datain;
    logic [DATA_W-1:0] m_dataout;
    logic [1:0]        owner;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_dataout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, m_we, m_addr, m_datain, owner
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_dataout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, m_we, m_addr, m_datain, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory/I-O port between the CPU (port 0) and a
// debug/loader master (port 1), with burst length bounded by STARVE_LIMIT.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          resetn,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t            state;
    logic [7:0]        cnt;
    logic              lp;
    logic              pick0;
    logic              pick1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;

    // Grant decision; lp only matters for a tie out of IDLE, and the owner yields
    // once it has used its full burst while the other port waits.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        case (state)
            OWN0: begin
                if (bus.req0 && !(bus.req1 && cnt == LIMIT)) pick0 = 1'b1;
                else if (bus.req1)                           pick1 = 1'b1;
            end
            OWN1: begin
                if (bus.req1 && !(bus.req0 && cnt == LIMIT)) pick1 = 1'b1;
                else if (bus.req0)                           pick0 = 1'b1;
            end
            default: begin
                if (bus.req0 && bus.req1) begin
                    pick0 = lp;
                    pick1 = ~lp;
                end else begin
                    pick0 = bus.req0;
                    pick1 = bus.req1;
                end
            end
        endcase
        gnt0 = pick0 & resetn;
        gnt1 = pick1 & resetn;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            lp      <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid0 <= gnt0 & ~bus.we0;
            rvalid1 <= gnt1 & ~bus.we1;
            if ((gnt0 & ~bus.we0) | (gnt1 & ~bus.we1)) rdata <= bus.m_dataout;
            // cnt saturates rather than wrapping so a lone requester keeps the port.
            if (gnt0) begin
                state <= OWN0;
                lp    <= 1'b0;
                if (state == OWN0) cnt <= (cnt < LIMIT) ? cnt + 8'd1 : cnt;
                else               cnt <= 8'd1;
            end else if (gnt1) begin
                state <= OWN1;
                lp    <= 1'b1;
                if (state == OWN1) cnt <= (cnt < LIMIT) ? cnt + 8'd1 : cnt;
                else               cnt <= 8'd1;
            end else begin
                state <= IDLE;
                cnt   <= 8'd0;
            end
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.rvalid0  = rvalid0;
    assign bus.rvalid1  = rvalid1;
    assign bus.rdata    = rdata;
    assign bus.owner    = state;
    assign bus.m_we     = resetn & ((gnt0 & bus.we0) | (gnt1 & bus.we1));
    assign bus.m_addr   = gnt0 ? bus.addr0  : (gnt1 ? bus.addr1  : '0);
    assign bus.m_datain = gnt0 ? bus.wdata0 : (gnt1 ? bus.wdata1 : '0);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with STARVE_LIMIT = 4.
module tb_dmem_arbiter;
    logic clock;
    logic resetn;
    int   vectors;
    int   miscompares;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic r1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [31:0] mem);
        @(posedge clock);
        #1;
        bus.req0      = r0;
        bus.we0       = w0;
        bus.addr0     = a0;
        bus.wdata0    = d0;
        bus.req1      = r1;
        bus.we1       = w1;
        bus.addr1     = a1;
        bus.wdata1    = d1;
        bus.m_dataout = mem;
        @(negedge clock);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        resetn        = 1'b0;
        bus.req0      = 1'b1;
        bus.req1      = 1'b1;
        bus.we0       = 1'b1;
        bus.we1       = 1'b0;
        bus.addr0     = 32'h4;
        bus.addr1     = 32'h8;
        bus.wdata0    = 32'h0;
        bus.wdata1    = 32'h0;
        bus.m_dataout = 32'h0;

        repeat (2) @(negedge clock);
        checkOutput("rst_gnt0",    bus.gnt0,    0);
        checkOutput("rst_gnt1",    bus.gnt1,    0);
        checkOutput("rst_m_we",    bus.m_we,    0);
        checkOutput("rst_rvalid0", bus.rvalid0, 0);
        checkOutput("rst_rvalid1", bus.rvalid1, 0);
        checkOutput("rst_owner",   bus.owner,   0);
        checkOutput("rst_rdata",   bus.rdata,   0);

        resetn = 1'b1;
        #1;
        checkOutput("tie_gnt0", bus.gnt0, 1);
        checkOutput("tie_gnt1", bus.gnt1, 0);
        checkOutput("tie_m_we", bus.m_we, 1);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("tie_owner", bus.owner, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_owner", bus.owner, 0);

        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        checkOutput("rd_gnt0",   bus.gnt0,   1);
        checkOutput("rd_gnt1",   bus.gnt1,   0);
        checkOutput("rd_m_addr", bus.m_addr, 32'h10);
        checkOutput("rd_m_we",   bus.m_we,   0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_rvalid0", bus.rvalid0, 1);
        checkOutput("rd_rdata",   bus.rdata,   32'hDEADBEEF);
        checkOutput("rd_rvalid1", bus.rvalid1, 0);
        checkOutput("rd_owner",   bus.owner,   1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_pulse_end", bus.rvalid0, 0);

        applyStimulus(0, 0, 0, 0, 1, 1, 32'h80, 32'h12345678, 0);
        checkOutput("wr_gnt1",     bus.gnt1,     1);
        checkOutput("wr_gnt0",     bus.gnt0,     0);
        checkOutput("wr_m_we",     bus.m_we,     1);
        checkOutput("wr_m_addr",   bus.m_addr,   32'h80);
        checkOutput("wr_m_datain", bus.m_datain, 32'h12345678);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_rvalid1", bus.rvalid1, 0);
        checkOutput("wr_owner",   bus.owner,   2);

        // Runs of four: port 0 in 0-3, port 1 in 4-7, port 0 in 8-11, port 1 in 12-15.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, 32'h100, 32'h1, 1, 1, 32'h200, 32'h2, 0);
            checkOutput($sformatf("cont_gnt0_%0d", i), bus.gnt0, ((i / 4) % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("cont_gnt1_%0d", i), bus.gnt1, ((i / 4) % 2 == 1) ? 1 : 0);
        end

        applyStimulus(1, 1, 32'h100, 32'h1, 0, 0, 0, 0, 0);
        checkOutput("hand_gnt0",  bus.gnt0,  1);
        checkOutput("hand_gnt1",  bus.gnt1,  0);
        checkOutput("hand_owner", bus.owner, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hand_owner_next", bus.owner, 1);

        applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0, 32'hCAFEF00D);
        checkOutput("rstrd_gnt0", bus.gnt0, 1);
        @(posedge clock);
        #1;
        resetn   = 1'b0;
        bus.req0 = 1'b0;
        #1;
        checkOutput("rstrd_rvalid0", bus.rvalid0, 0);
        checkOutput("rstrd_owner",   bus.owner,   0);
        checkOutput("rstrd_rdata",   bus.rdata,   0);
        @(negedge clock);
        resetn = 1'b1;

        // Fresh lp and cnt after reset: port 0 wins the tie and keeps four cycles.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 32'h100, 32'h1, 1, 1, 32'h200, 32'h2, 0);
            checkOutput($sformatf("post_gnt0_%0d", i), bus.gnt0, (i < 4) ? 1 : 0);
            checkOutput($sformatf("post_gnt1_%0d", i), bus.gnt1, (i < 4) ? 0 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
